// File: rtl/dma_pkg.sv
// Shared definitions for the OAM DMA controller.
//   dma_state_e  : controller states
//   XFER_LEN_DEF : default bytes per transfer (OAM size)
//   ECHO_THR     : first source page that falls in the echo-RAM mirror
//   ECHO_OFS     : distance from an echo page back to its work-RAM page
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_LAST  = 2'd3
  } dma_state_e;

  localparam int          XFER_LEN_DEF = 160;
  localparam logic [7:0]  ECHO_THR     = 8'hE0;
  localparam logic [7:0]  ECHO_OFS     = 8'h20;

  // High address byte actually driven on the source bus for a given page.
  function automatic logic [7:0] src_hi(input logic [7:0] src);
    return (src >= ECHO_THR) ? (src - ECHO_OFS) : src;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a write to FF46 copies XFER_LEN bytes from page
// {src,00} of the source bus into OAM starting at OAM_BASE.
// Ports:
//   clk, nreset           : machine-cycle clock, async active-low reset
//   ff46_wr, d_in, d_out  : DMA source register write strobe / data / readback
//   dma_rd, dma_addr,
//   dma_rdata             : source bus read request, address, returned byte
//   oam_we, oam_addr,
//   oam_wdata             : OAM write port
//   dma_busy              : OAM owned by DMA
module oam_dma_ctrl
  import dma_pkg::*;
#(
  parameter int         XFER_LEN = XFER_LEN_DEF,
  parameter logic [7:0] OAM_BASE = 8'h00
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        ff46_wr,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_busy
);

  localparam logic [7:0] LAST_CNT = 8'(XFER_LEN - 1);

  dma_state_e r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_src;
  logic [7:0] r_rdata;
  logic       r_busy_q;   // dma_busy of the previous cycle, held through START

  logic       w_xfer;
  logic       w_last;
  logic [7:0] w_hi;

  assign w_xfer = (r_state == ST_XFER);
  assign w_last = (r_state == ST_LAST);
  assign w_hi   = src_hi(r_src);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'h00;
      r_src    <= 8'h00;
      r_rdata  <= 8'h00;
      r_busy_q <= 1'b0;
    end else begin
      r_busy_q <= dma_busy;
      if (ff46_wr) begin
        // A write restarts from byte 0; the read captured this cycle is
        // discarded with the old transfer.
        r_src   <= d_in;
        r_state <= ST_START;
        r_cnt   <= 8'h00;
      end else begin
        unique case (r_state)
          ST_START: r_state <= ST_XFER;
          ST_XFER: begin
            r_rdata <= dma_rdata;
            r_cnt   <= r_cnt + 8'd1;
            if (r_cnt == LAST_CNT) r_state <= ST_LAST;
          end
          ST_LAST: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign d_out    = r_src;
  assign dma_rd   = w_xfer;
  assign dma_addr = w_xfer ? {w_hi, r_cnt} : 16'h0000;

  // Writes trail reads by one cycle: XFER at cnt writes byte cnt-1, and LAST
  // flushes the final byte.
  assign oam_we    = (w_xfer && (r_cnt != 8'h00)) || w_last;
  assign oam_addr  = oam_we ? (OAM_BASE + r_cnt - 8'd1) : OAM_BASE;
  assign oam_wdata = oam_we ? r_rdata : 8'h00;

  assign dma_busy = w_xfer || w_last || ((r_state == ST_START) && r_busy_q);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: table of source pages run through
// full transfers, then hand sequences for restart, back-to-back writes and
// reset mid-transfer. The source bus returns the low address byte.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        ff46_wr = 1'b0;
  logic [7:0]  d_in = 8'h00;
  logic [7:0]  d_out;
  logic        dma_rd;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign dma_rdata = dma_addr[7:0];

  oam_dma_ctrl #(.XFER_LEN(160), .OAM_BASE(8'h00)) dut (
    .clk(clk), .nreset(nreset), .ff46_wr(ff46_wr), .d_in(d_in), .d_out(d_out),
    .dma_rd(dma_rd), .dma_addr(dma_addr), .dma_rdata(dma_rdata),
    .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .dma_busy(dma_busy)
  );

  logic [34:0] act_vec;
  assign act_vec = {dma_busy, dma_rd, dma_addr, oam_we, oam_addr, oam_wdata};

  typedef struct {
    logic [7:0] src;
    logic [7:0] hi;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected {busy, rd, addr, we, oam_addr, wdata} k cycles after the FF46
  // write edge: k=0 START, k=1..160 XFER, k=161 LAST, k=162 IDLE.
  function automatic logic [34:0] exp_out(input int k, input logic [7:0] hi, input logic pb);
    logic b, r, w;
    logic [15:0] a;
    logic [7:0] oa, wd;
    b  = (k == 0) ? pb : (k <= 161);
    r  = (k >= 1) && (k <= 160);
    a  = r ? {hi, 8'(k - 1)} : 16'h0000;
    w  = (k >= 2) && (k <= 161);
    oa = w ? 8'(k - 2) : 8'h00;
    wd = w ? 8'(k - 2) : 8'h00;
    return {b, r, a, w, oa, wd};
  endfunction

  // Called at a negedge; leaves at the negedge after the write edge.
  task automatic wr_byte(input logic [7:0] v);
    ff46_wr = 1'b1;
    d_in    = v;
    @(negedge clk);
    ff46_wr = 1'b0;
  endtask

  task automatic watch(input logic [7:0] hi, input logic pb, input int n);
    int we_n;
    int bz_n;
    we_n = 0;
    bz_n = 0;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("xfer hi=%h k=%0d", hi, k), 64'(act_vec), 64'(exp_out(k, hi, pb)));
      if (k > 0 && dma_busy) bz_n++;
      if (oam_we) we_n++;
      @(negedge clk);
    end
    if (n == 163) begin
      chk($sformatf("write count hi=%h", hi), 64'(we_n), 64'd160);
      chk($sformatf("busy cycles hi=%h", hi), 64'(bz_n), 64'd161);
    end
  endtask

  task automatic run_xfer(input logic [7:0] src, input logic [7:0] hi, input logic pb, input int n);
    wr_byte(src);
    watch(hi, pb, n);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{src: 8'hC1, hi: 8'hC1};
    vecs[1] = '{src: 8'hE3, hi: 8'hC3};
    vecs[2] = '{src: 8'hFF, hi: 8'hDF};
    vecs[3] = '{src: 8'hE0, hi: 8'hC0};
    vecs[4] = '{src: 8'hDF, hi: 8'hDF};
    vecs[5] = '{src: 8'h00, hi: 8'h00};

    // Reset state
    #3;
    chk("reset outputs", 64'(act_vec), 64'h0);
    chk("reset d_out", 64'(d_out), 64'h0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("idle after release", 64'(act_vec), 64'h0);

    // Table-driven full transfers
    foreach (vecs[i]) begin
      run_xfer(vecs[i].src, vecs[i].hi, 1'b0, 163);
      chk($sformatf("d_out src=%h", vecs[i].src), 64'(d_out), 64'(vecs[i].src));
    end

    // Restart at cnt=50: START keeps busy high, no write, fresh 160 writes
    run_xfer(8'h80, 8'h80, 1'b0, 51);
    chk("pre-restart cnt50 addr", 64'(dma_addr), 64'h8032);
    run_xfer(8'h90, 8'h90, 1'b1, 163);
    chk("restart d_out", 64'(d_out), 64'h90);

    // Two consecutive FF46 writes: single transfer from the second value
    ff46_wr = 1'b1;
    d_in    = 8'hA0;
    @(negedge clk);
    d_in    = 8'hA1;
    @(negedge clk);
    ff46_wr = 1'b0;
    watch(8'hA1, 1'b0, 163);
    chk("b2b d_out", 64'(d_out), 64'hA1);

    // Reset mid-transfer at cnt=100
    run_xfer(8'hC1, 8'hC1, 1'b0, 101);
    chk("pre-reset cnt100 addr", 64'(dma_addr), 64'hC164);
    #2;
    nreset = 1'b0;
    #1;
    chk("async reset outputs", 64'(act_vec), 64'h0);
    chk("async reset d_out", 64'(d_out), 64'h0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("post-reset idle k=%0d", k), 64'({dma_busy, dma_rd, oam_we}), 64'h0);
      @(negedge clk);
    end

    // New transfer after reset still works
    run_xfer(8'hC2, 8'hC2, 1'b0, 163);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
